coin_feeder: RTL and testbench
==============================

COIN_FEEDER -- requirements
Module: coin_feeder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 4, giving the number of consecutive stable synchronized samples needed to qualify a sensor level.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of coin-FIFO entries (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port s5, input, 1 bit: raw asynchronous sensor level for a 5-unit coin.
REQ-006 The block SHALL have port s10, input, 1 bit: raw asynchronous sensor level for a 10-unit coin.
REQ-007 The block SHALL have port hold, input, 1 bit: downstream pause; while high, no new coin starts emission.
REQ-008 The block SHALL have port coin, output, 2 bits: registered coin code to the vending FSM (00 none, 01 five, 10 ten; 11 never driven).
REQ-009 The block SHALL have port pending, output, clog2(DEPTH)+1 bits: registered FIFO occupancy.
REQ-010 The block SHALL have port full, output, 1 bit: registered; high when pending equals DEPTH.
REQ-011 The block SHALL have port reject, output, 1 bit: registered single-cycle pulse for a dropped coin.

Function
REQ-012 Each sensor SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-013 Each sensor SHALL have a debouncer with states ARMED and LATCHED and a stability counter.
- ARMED: count consecutive high samples. On reaching DEBOUNCE, go to LATCHED and raise a one-cycle qualify event. A low sample clears the count.
- LATCHED: count consecutive low samples. On reaching DEBOUNCE, go to ARMED. A high sample clears the count.
- Result: a held-high sensor yields exactly one coin; glitches shorter than DEBOUNCE yield none.
REQ-014 When both qualify events fire in the same cycle, the block SHALL queue neither coin and SHALL pulse reject for one cycle.
REQ-015 A single qualify event SHALL push its code into the FIFO on that edge when the registered pending is below DEPTH. Otherwise the coin SHALL be dropped and reject pulsed.
- Full is judged on the pre-edge count, so a simultaneous pop does not make room.
REQ-016 The emitter FSM SHALL have states IDLE, EMIT and GAP.
- IDLE: if the FIFO is non-empty and hold is low, pop the head, drive coin with the popped code on the next cycle, and go to EMIT.
- EMIT: coin holds the code for exactly one cycle, then go to GAP.
- GAP: coin=00 for exactly one cycle, then go to IDLE.
REQ-017 hold SHALL be sampled only in IDLE. Raising hold during EMIT or GAP SHALL NOT truncate the current pulse or gap.
REQ-018 Coins SHALL be emitted in arrival order. The peak emission rate is one coin per two cycles, and coin never holds a non-zero value for two consecutive cycles.
REQ-019 A simultaneous push and pop SHALL leave pending unchanged and preserve order.
REQ-020 pending SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-021 Minimum latency SHALL be 2+DEBOUNCE+1 rising edges, measured from the first edge sampling the sensor high to coin becoming non-zero. This is 7 edges at default, with the FIFO empty, the FSM in IDLE and hold low.

Reset
REQ-022 While rst is low, the block SHALL immediately force: coin=00, pending=0, full=0, reject=0, both debouncers ARMED with counts 0, synchronizers 0, FIFO pointers 0, FSM in IDLE.
REQ-023 Reset asserted mid-EMIT SHALL drop the in-flight coin and all queued coins. No coin SHALL be emitted after release until a new qualification occurs.
REQ-024 A sensor still high at reset release SHALL be qualified as a new coin after DEBOUNCE synchronized high samples.

Verification
REQ-025 The bench SHALL apply s10 high for 10 cycles, then low; coin=10 for exactly one cycle at edge 7, then 00, with pending back to 0.
REQ-026 The bench SHALL apply s5 pulses 2 cycles wide, repeated; no coin is emitted and reject stays 0.
REQ-027 The bench SHALL hold hold=1 and deliver 5, 5, 10, 5 (each 8 high / 8 low); pending goes 1, 2, 3, 4 and full=1. A fifth coin (10) produces a reject pulse with pending staying at 4. After hold is released, the output is 01, 01, 10, 01, each pulse separated by one 00 cycle.
REQ-028 The bench SHALL raise s5 and s10 on the same edge, held for 8 cycles; one reject pulse results, pending=0, and coin stays 00.
REQ-029 The bench SHALL queue 2 coins, assert rst low during EMIT of the first, then release; all outputs are 0 at once, no further coin appears, and a subsequent s10 coin emits normally.
REQ-030 The bench SHALL drive a 10+10 sequence into the vending FSM through this block; the FSM sees two isolated coin=10 pulses, one cycle each, and dispense asserts once.

Source files
------------

// File: rtl/coin_feeder.sv
// coin_feeder: debounces two coin sensors, queues qualified coins in a FIFO and emits them
// as single-cycle codes separated by one idle cycle.
module coin_feeder #(
  parameter int DEBOUNCE = 4,
  parameter int DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s5,
  input  logic                    s10,
  input  logic                    hold,
  output logic [1:0]              coin,
  output logic [$clog2(DEPTH):0]  pending,
  output logic                    full,
  output logic                    reject
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEBOUNCE + 1);
  typedef enum logic {ARMED, LATCHED} db_t;
  typedef enum logic [1:0] {IDLE, EMIT, GAP} em_t;
  logic [1:0] r_sync1, r_sync2, w_qual;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {s10, s5};
      r_sync2 <= r_sync1;
    end
  for (genvar g = 0; g < 2; g++) begin : g_db
    db_t           r_dst;
    logic [CW-1:0] r_cnt;
    logic          w_done;
    assign w_done    = r_cnt == CW'(DEBOUNCE - 1);
    assign w_qual[g] = r_dst == ARMED && r_sync2[g] && w_done;
    // a sample equal to the latched level breaks the run toward the opposite level
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        r_dst <= ARMED;
        r_cnt <= '0;
      end else if (r_sync2[g] == (r_dst == LATCHED)) r_cnt <= '0;
      else if (w_done) begin
        r_dst <= r_dst == ARMED ? LATCHED : ARMED;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
  end
  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_pend, w_pend_nx;
  logic [1:0]    r_coin, w_code;
  logic          r_full, r_reject, w_one, w_push, w_pop;
  em_t           r_st;
  assign w_one     = w_qual[0] ^ w_qual[1];
  assign w_code    = w_qual[1] ? 2'b10 : 2'b01;
  assign w_push    = w_one && r_pend < (AW+1)'(DEPTH);
  // GAP doubles as the IDLE decision point so back-to-back coins get a single 00 cycle
  assign w_pop     = r_st != EMIT && r_pend != '0 && !hold;
  assign w_pend_nx = r_pend + (AW+1)'(w_push) - (AW+1)'(w_pop);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wp     <= '0;
      r_pend   <= '0;
      r_full   <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_pend   <= w_pend_nx;
      r_full   <= w_pend_nx == (AW+1)'(DEPTH);
      r_reject <= (&w_qual) || (w_one && !w_push);
      if (w_push) r_wp <= r_wp + 1'b1;
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= w_code;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_st   <= IDLE;
      r_rp   <= '0;
      r_coin <= 2'b00;
    end else if (w_pop) begin
      r_st   <= EMIT;
      r_rp   <= r_rp + 1'b1;
      r_coin <= r_mem[r_rp];
    end else begin
      r_st   <= r_st == EMIT ? GAP : IDLE;
      r_coin <= 2'b00;
    end
  assign coin    = r_coin;
  assign pending = r_pend;
  assign full    = r_full;
  assign reject  = r_reject;
endmodule

// File: tb/tb_coin_feeder.sv
// tb_coin_feeder: directed and random stimulus against a queue-based reference of the coin feeder.
module tb_coin_feeder;
  localparam int DEB = 4;
  localparam int DEP = 4;
  logic       clk = 1'b0, rst = 1'b1, s5 = 1'b0, s10 = 1'b0, hold = 1'b0;
  logic [1:0] coin;
  logic [2:0] pending;
  logic       full, reject;
  coin_feeder #(.DEBOUNCE(DEB), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .s5(s5), .s10(s10), .hold(hold),
    .coin(coin), .pending(pending), .full(full), .reject(reject)
  );
  always #5 clk = ~clk;
  int n_pass = 0, n_chk = 0;
  int m_coin, m_pend, m_cyc, m_last, m_run [2];
  bit m_full, m_reject, m_d1 [2], m_d2 [2], m_lvl [2];
  int mq [$];
  int prev_coin, seen, rej, credit, disp;
  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  task automatic model_reset();
    mq.delete();
    m_coin = 0; m_pend = 0; m_full = 0; m_reject = 0; m_cyc = 0; m_last = -10;
    for (int i = 0; i < 2; i++) begin
      m_d1[i] = 0; m_d2[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
    end
  endtask
  // sensor level flips after DEB synchronized samples disagreeing with it; a rising flip is a coin
  task automatic model_step();
    bit q [2];
    bit pop, full_pre;
    for (int i = 0; i < 2; i++) begin
      q[i] = 0;
      if (m_d2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = m_d2[i]; m_run[i] = 0; q[i] = m_lvl[i];
        end
      end else m_run[i] = 0;
    end
    pop      = m_cyc >= m_last + 2 && mq.size() > 0 && !hold;
    full_pre = mq.size() == DEP;
    m_reject = (q[0] && q[1]) || ((q[0] ^ q[1]) && full_pre);
    m_coin   = 0;
    if (pop) begin
      m_coin = mq.pop_front();
      m_last = m_cyc;
    end
    if ((q[0] ^ q[1]) && !full_pre) mq.push_back(q[1] ? 2 : 1);
    m_pend = mq.size();
    m_full = m_pend == DEP;
    m_d2 = m_d1;
    m_d1[0] = s5; m_d1[1] = s10;
    m_cyc++;
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("coin", int'(coin), m_coin);
    chk("pending", int'(pending), m_pend);
    chk("full", int'(full), int'(m_full));
    chk("reject", int'(reject), int'(m_reject));
    chk("no_back_to_back", int'(prev_coin != 0 && coin != 0), 0);
    prev_coin = int'(coin);
    if (coin != 0) seen++;
    if (reject) rej++;
    credit += coin == 2'b10 ? 10 : coin == 2'b01 ? 5 : 0;
    if (credit >= 20) begin
      credit -= 20;
      disp++;
    end
  endtask
  task automatic do_reset(int cycles);
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_coin", int'(coin), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_reject", int'(reject), 0);
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b1;
    prev_coin = 0;
  endtask
  task automatic feed(int code, int hi, int lo);
    s5  = (code & 1) != 0;
    s10 = (code & 2) != 0;
    repeat (hi) tick();
    s5 = 1'b0; s10 = 1'b0;
    repeat (lo) tick();
  endtask
  initial begin
    int seq [$], at [$];
    int exp_seq [4] = '{1, 1, 2, 1};
    #2 do_reset(3);
    s10 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6) chk("lat_before7", int'(coin), 0);
      if (i == 7) chk("lat_at7", int'(coin), 2);
      if (i == 8) chk("lat_after7", int'(coin), 0);
    end
    s10 = 1'b0;
    repeat (10) tick();
    chk("s10_drained", int'(pending), 0);
    seen = 0; rej = 0;
    repeat (6) feed(1, 2, 4);
    repeat (6) tick();
    chk("glitch_coins", seen, 0);
    chk("glitch_rejects", rej, 0);
    hold = 1'b1; seen = 0;
    feed(1, 8, 8); chk("hold_pend1", int'(pending), 1);
    feed(1, 8, 8); chk("hold_pend2", int'(pending), 2);
    feed(2, 8, 8); chk("hold_pend3", int'(pending), 3);
    feed(1, 8, 8); chk("hold_pend4", int'(pending), 4);
    chk("hold_full", int'(full), 1);
    rej = 0;
    feed(2, 8, 8);
    chk("fifth_reject", rej, 1);
    chk("fifth_pend", int'(pending), 4);
    chk("held_no_coin", seen, 0);
    hold = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (coin != 0) begin
        seq.push_back(int'(coin));
        at.push_back(i);
      end
    end
    chk("drain_count", seq.size(), 4);
    for (int k = 0; k < 4 && k < seq.size(); k++) begin
      chk("drain_order", seq[k], exp_seq[k]);
      if (k > 0) chk("drain_spacing", at[k] - at[k-1], 2);
    end
    chk("drain_pend", int'(pending), 0);
    rej = 0; seen = 0;
    feed(3, 8, 10);
    chk("both_rejects", rej, 1);
    chk("both_pend", int'(pending), 0);
    chk("both_coins", seen, 0);
    hold = 1'b1;
    feed(1, 8, 8);
    feed(2, 8, 8);
    hold = 1'b0;
    for (int i = 0; i < 10 && coin == 2'b00; i++) tick();
    chk("pre_reset_emit", int'(coin), 1);
    do_reset(2);
    seen = 0;
    repeat (15) tick();
    chk("post_reset_silent", seen, 0);
    feed(2, 8, 8);
    chk("post_reset_coin", seen, 1);
    s5 = 1'b1;
    tick();
    do_reset(2);
    seen = 0;
    repeat (10) tick();
    chk("high_at_release", seen, 1);
    s5 = 1'b0;
    repeat (10) tick();
    seen = 0; credit = 0; disp = 0;
    feed(2, 8, 8);
    feed(2, 8, 8);
    repeat (6) tick();
    chk("vend_pulses", seen, 2);
    chk("vend_dispense", disp, 1);
    for (int seg = 0; seg < 160; seg++) begin
      s5   = 1'($urandom_range(0, 1));
      s10  = 1'($urandom_range(0, 1));
      hold = $urandom_range(0, 3) == 0;
      repeat ($urandom_range(1, 9)) tick();
    end
    s5 = 1'b0; s10 = 1'b0; hold = 1'b0;
    repeat (30) tick();
    chk("final_pend", int'(pending), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
